tc_alu_seq: RTL and testbench
=============================

TC_ALU_SEQ -- requirements
Module: tc_alu_seq

Interface
REQ-001 SHALL have parameter: width, 11, operand/result width in bits (two's complement).
REQ-002 SHALL have port: Clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: Reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port: Start  input  1  request operation; sampled only in IDLE.
REQ-005 SHALL have port: Op  input  2  operation code: 00 add, 01 subtract, 10 multiply, 11 negate A.
REQ-006 SHALL have port: A  input  width  two's-complement operand A, as produced by the sign-magnitude-to-two's-complement stage.
REQ-007 SHALL have port: B  input  width  two's-complement operand B (ignored for negate).
REQ-008 SHALL have port: Result  output  width  two's-complement result, feeding the two's-complement-to-sign-magnitude stage.
REQ-009 SHALL have port: Overflow  output  1  exact result outside [-2^(width-1), 2^(width-1)-1].
REQ-010 SHALL have port: Busy  output  1  operation in progress.
REQ-011 SHALL have port: Done  output  1  single-cycle pulse; Result/Overflow valid from this cycle.

Function
REQ-012 SHALL implement states IDLE, EXEC, MUL, DONE.
REQ-013 SHALL, in IDLE with Start=1 at edge k, latch A, B, Op, set Busy=1 from k+1, go to EXEC (Op 00/01/11) or MUL (Op 10).
REQ-014 SHALL, in EXEC, compute the result in width+1 bits, register the low width bits into Result and the overflow flag, and go to DONE; add/sub/negate Done high in cycle after edge k+2.
REQ-015 SHALL compute multiply as sequential shift-add of width-bit operand magnitudes (magnitude of -2^(width-1) is 2^(width-1)), one partial product per cycle for width cycles, sign = XOR of operand signs.
REQ-016 SHALL set multiply Result to the low width bits of the exact two's-complement product, Overflow when the product is out of range; multiply Done high after edge k+1+width.
REQ-017 SHALL treat a zero product as positive zero regardless of operand signs.
REQ-018 SHALL flag Overflow for negate only when A = -2^(width-1), with Result = A.
REQ-019 SHALL assert Done for exactly one cycle in DONE, then return to IDLE with Busy=0 on the same edge that leaves DONE.
REQ-020 SHALL ignore Start while Busy=1; latched operands are unaffected by A/B/Op changes after edge k.
REQ-021 SHALL hold Result and Overflow stable from Done until the next Done.
REQ-022 SHALL accept Start in the cycle after Done (back-to-back operations, no dead cycle beyond DONE).

Reset
REQ-023 SHALL, on Reset_n=0, immediately force state IDLE, Result=0, Overflow=0, Busy=0, Done=0, clear multiplier registers and cycle counter.
REQ-024 SHALL abort any operation in progress on reset with no Done pulse; first Start after Reset_n deasserts is accepted normally.

Structure
REQ-025 SHALL place Op encodings and the state enumeration in shared package tc_alu_pkg.
REQ-026 SHALL implement the shift-add multiplier as sub-module tc_mul_seq (start, magnitudes in, 2*width product out, done), clocked by Clock and reset by Reset_n.
REQ-027 SHALL size the multiplier cycle counter as clog2(width)+1 bits, fully parameterised on width.

Verification (width=11)
REQ-028 SHALL test add 1000+100 -> Result=-948, Overflow=1, Done after edge k+2.
REQ-029 SHALL test subtract -5-3 -> Result=-8, Overflow=0; then back-to-back add 7+(-7) started the cycle after Done -> Result=0.
REQ-030 SHALL test multiply -25*40 -> Result=-1000, Overflow=0, Done after edge k+12; 32*32 -> Result=-1024, Overflow=1; -32*32 -> Result=-1024, Overflow=0; -3*0 -> Result=0.
REQ-031 SHALL test negate A=-1024 -> Result=-1024, Overflow=1; A=5 -> Result=-5, Overflow=0.
REQ-032 SHALL test Start pulsed with new operands during multiply Busy -> ignored, original product delivered.
REQ-033 SHALL test Reset_n low at cycle 5 of multiply -> all outputs 0 immediately, no Done; next Start 2*3 -> Result=6.

Source files
------------

// File: rtl/tc_alu_pkg.sv
// Shared encodings for the sequential two's-complement ALU.
// Holds the operation codes and the controller state enumeration.
package tc_alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_NEG = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    MUL  = 2'b10,
    DONE = 2'b11
  } state_e;

endpackage

// File: rtl/tc_mul_seq.sv
// Unsigned shift-add multiplier: one partial product per clock for width clocks.
// Loads magnitudes on start; done pulses for one cycle once product is final.
module tc_mul_seq #(
  parameter int width = 11
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [width-1:0]     mag_a,
  input  logic [width-1:0]     mag_b,
  output logic [2*width-1:0]   product,
  output logic                 done
);

  localparam int cw = $clog2(width) + 1;

  logic [2*width-1:0] mcand;
  logic [width-1:0]   mplier;
  logic [cw-1:0]      count;
  logic               active;

  // Multiplicand shifts left and multiplier right, so bit 0 of mplier selects each partial product.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mcand   <= '0;
      mplier  <= '0;
      count   <= '0;
      active  <= 1'b0;
      product <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        mcand   <= {{width{1'b0}}, mag_a};
        mplier  <= mag_b;
        product <= '0;
        count   <= '0;
        active  <= 1'b1;
      end else if (active) begin
        if (mplier[0]) begin
          product <= product + mcand;
        end
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        count  <= count + cw'(1);
        if (count == cw'(width - 1)) begin
          active <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/tc_alu_seq.sv
// Sequential two's-complement ALU: add, subtract, negate in EXEC; multiply
// via the shift-add sub-module with sign applied on the magnitude product.
module tc_alu_seq
  import tc_alu_pkg::*;
#(
  parameter int width = 11
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [width-1:0] A,
  input  logic [width-1:0] B,
  output logic [width-1:0] Result,
  output logic             Overflow,
  output logic             Busy,
  output logic             Done
);

  state_e             state;
  op_e                op_q;
  logic [width-1:0]   a_q;
  logic [width-1:0]   b_q;
  logic               sign_q;
  logic [width:0]     wide_q;
  logic               exec_phase;

  logic [width:0]     exact;
  logic [width-1:0]   mag_a;
  logic [width-1:0]   mag_b;
  logic               mul_go;
  logic [2*width-1:0] mul_product;
  logic               mul_done;
  logic [2*width-1:0] prod_signed;
  logic [width:0]     prod_upper;
  logic               mul_ovf;

  function automatic logic [width-1:0] mag(input logic [width-1:0] v);
    return v[width-1] ? (~v + width'(1)) : v;
  endfunction

  assign mag_a  = mag(A);
  assign mag_b  = mag(B);
  assign mul_go = (state == IDLE) && Start && (Op == OP_MUL);

  always_comb begin
    exact = '0;
    case (op_q)
      OP_ADD:  exact = {a_q[width-1], a_q} + {b_q[width-1], b_q};
      OP_SUB:  exact = {a_q[width-1], a_q} - {b_q[width-1], b_q};
      default: exact = (width+1)'(0) - {a_q[width-1], a_q};
    endcase
  end

  // A zero product stays positive zero, so the sign only applies to non-zero magnitudes.
  assign prod_signed = (sign_q && (mul_product != '0)) ? ((2*width)'(0) - mul_product) : mul_product;
  assign prod_upper  = prod_signed[2*width-1:width-1];
  assign mul_ovf     = !((&prod_upper) || (prod_upper == '0));

  tc_mul_seq #(.width(width)) u_mul (
    .clock   (Clock),
    .reset_n (Reset_n),
    .start   (mul_go),
    .mag_a   (mag_a),
    .mag_b   (mag_b),
    .product (mul_product),
    .done    (mul_done)
  );

  // The width+1 exact value gets its own register stage before Result is updated.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      op_q       <= OP_ADD;
      a_q        <= '0;
      b_q        <= '0;
      sign_q     <= 1'b0;
      wide_q     <= '0;
      exec_phase <= 1'b0;
      Result     <= '0;
      Overflow   <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            a_q        <= A;
            b_q        <= B;
            op_q       <= op_e'(Op);
            sign_q     <= A[width-1] ^ B[width-1];
            exec_phase <= 1'b0;
            Busy       <= 1'b1;
            state      <= (Op == OP_MUL) ? MUL : EXEC;
          end
        end
        EXEC: begin
          if (!exec_phase) begin
            wide_q     <= exact;
            exec_phase <= 1'b1;
          end else begin
            Result   <= wide_q[width-1:0];
            Overflow <= wide_q[width] ^ wide_q[width-1];
            Done     <= 1'b1;
            state    <= DONE;
          end
        end
        MUL: begin
          if (mul_done) begin
            Result   <= prod_signed[width-1:0];
            Overflow <= mul_ovf;
            Done     <= 1'b1;
            state    <= DONE;
          end
        end
        default: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tc_alu_seq.sv
// Scoreboard bench for tc_alu_seq: directed corner cases plus random traffic
// checked against an integer-arithmetic reference model.
module tb_tc_alu_seq;

  localparam int W = 11;

  logic         Clock = 1'b0;
  logic         Reset_n = 1'b0;
  logic         Start = 1'b0;
  logic [1:0]   Op = 2'b00;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [W-1:0] Result;
  logic         Overflow;
  logic         Busy;
  logic         Done;

  typedef struct {
    logic [W-1:0] res;
    logic         ovf;
    int           done_edge;
  } exp_t;

  exp_t sbq[$];

  int checks = 0;
  int errors = 0;
  int edges  = 0;
  logic [W-1:0] holdR = '0;
  logic         holdO = 1'b0;

  tc_alu_seq #(.width(W)) dut (
    .Clock    (Clock),
    .Reset_n  (Reset_n),
    .Start    (Start),
    .Op       (Op),
    .A        (A),
    .B        (B),
    .Result   (Result),
    .Overflow (Overflow),
    .Busy     (Busy),
    .Done     (Done)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) edges++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference: exact integer result, wrapped to W bits, overflow when outside the signed range.
  function automatic void model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] res, output logic ovf);
    int sa, sb, ex;
    logic [31:0] ev;
    sa = int'($signed(a));
    sb = int'($signed(b));
    case (op)
      2'd0:    ex = sa + sb;
      2'd1:    ex = sa - sb;
      2'd2:    ex = sa * sb;
      default: ex = -sa;
    endcase
    ovf = (ex < -(1 << (W-1))) || (ex > (1 << (W-1)) - 1);
    ev  = ex;
    res = ev[W-1:0];
  endfunction

  // Monitor: pops the scoreboard on every Done and checks that outputs hold in between.
  always @(negedge Clock) begin
    if (!Reset_n) begin
      holdR <= '0;
      holdO <= 1'b0;
    end else if (Done) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done: Done=1 with empty scoreboard at %0t", $time);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        checkOutput("result", 32'(Result), 32'(e.res));
        checkOutput("overflow", 32'(Overflow), 32'(e.ovf));
        checkOutput("latency", edges, e.done_edge);
        checkOutput("busy_at_done", 32'(Busy), 32'd1);
      end
      holdR <= Result;
      holdO <= Overflow;
    end else begin
      checkOutput("hold_result", 32'(Result), 32'(holdR));
      checkOutput("hold_overflow", 32'(Overflow), 32'(holdO));
    end
  end

  task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                               input int idle, input int poke);
    exp_t e;
    int n;
    repeat (idle) @(negedge Clock);
    @(negedge Clock);
    Start = 1'b1;
    Op    = op;
    A     = a;
    B     = b;
    model(op, a, b, e.res, e.ovf);
    e.done_edge = edges + 1 + ((op == 2'd2) ? (1 + W) : 2);
    sbq.push_back(e);
    @(negedge Clock);
    checkOutput("busy_after_start", 32'(Busy), 32'd1);
    Start = 1'b0;
    Op    = 2'($urandom);
    A     = W'($urandom);
    B     = W'($urandom);
    n = 0;
    while (!Done && n < 40) begin
      @(negedge Clock);
      n++;
      if (poke != 0 && n == poke) begin
        Start = 1'b1;
        Op    = 2'($urandom);
        A     = W'($urandom);
        B     = W'($urandom);
      end else begin
        Start = 1'b0;
      end
    end
    Start = 1'b0;
    if (!Done) checkOutput("done_timeout", 32'(Done), 32'd1);
  endtask

  function automatic logic [W-1:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return W'(-(1 << (W-1)));
      1:       return W'((1 << (W-1)) - 1);
      2:       return '0;
      3:       return '1;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #3;
    checkOutput("reset_result", 32'(Result), 32'd0);
    checkOutput("reset_overflow", 32'(Overflow), 32'd0);
    checkOutput("reset_busy", 32'(Busy), 32'd0);
    checkOutput("reset_done", 32'(Done), 32'd0);
    repeat (2) @(negedge Clock);
    #2 Reset_n = 1'b1;

    applyStimulus(2'd0, W'(1000), W'(100), 0, 0);
    applyStimulus(2'd1, W'(-5), W'(3), 1, 0);
    applyStimulus(2'd0, W'(7), W'(-7), 0, 0);
    applyStimulus(2'd2, W'(-25), W'(40), 1, 0);
    applyStimulus(2'd2, W'(32), W'(32), 0, 0);
    applyStimulus(2'd2, W'(-32), W'(32), 0, 0);
    applyStimulus(2'd2, W'(-3), W'(0), 0, 0);
    applyStimulus(2'd3, W'(-1024), W'(0), 0, 0);
    applyStimulus(2'd3, W'(5), W'(9), 0, 0);
    applyStimulus(2'd2, W'(-17), W'(23), 0, 4);

    // Abort a multiply five cycles in; nothing is queued, so any Done would be flagged.
    @(negedge Clock);
    Start = 1'b1; Op = 2'd2; A = W'(100); B = W'(-9);
    @(negedge Clock);
    Start = 1'b0;
    repeat (4) @(negedge Clock);
    #2 Reset_n = 1'b0;
    #1;
    checkOutput("abort_result", 32'(Result), 32'd0);
    checkOutput("abort_overflow", 32'(Overflow), 32'd0);
    checkOutput("abort_busy", 32'(Busy), 32'd0);
    checkOutput("abort_done", 32'(Done), 32'd0);
    repeat (2) @(negedge Clock);
    #2 Reset_n = 1'b1;
    repeat (16) @(negedge Clock);
    applyStimulus(2'd2, W'(2), W'(3), 0, 0);

    for (int i = 0; i < 150; i++) begin
      logic [1:0] op;
      int poke;
      op   = 2'($urandom_range(0, 3));
      poke = (op == 2'd2 && $urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : 0;
      applyStimulus(op, pickOperand(), pickOperand(), $urandom_range(0, 2), poke);
    end

    repeat (20) @(negedge Clock);
    checkOutput("scoreboard_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete at %0t", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
